rtc_timekeeper: RTL and testbench

//   Parametrised real-time-clock core for the Basys3 clock design.
//   - Divides the board clock into a one-second tick and keeps HH:MM:SS in BCD, stored internally in 24h form.
//   - Adds a 12h/24h display mode, one alarm with latch and acknowledge, and separate setting of time vs alarm.
//   - Sits between the debounced/edge-detected button pulses and the seven-segment/LED drivers.

---
 rtl/rtc_timekeeper.sv | 209 ++++++++++++++++++++
 tb/tb_rtc_timekeeper.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: one-second prescaler and HH:MM:SS BCD timekeeping, with a single
// alarm that latches until acknowledged and a registered 12h/24h display mux.
// Time and alarm are always stored in 24h BCD; the 12h form exists only on the outputs.

module rtc_timekeeper #(
   parameter int CLK_HZ        = 100_000_000,
   parameter int ALARM_RST_HR  = 7,
   parameter int ALARM_RST_MIN = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       hr_inc,
   input  logic       min_inc,
   input  logic       alm_set,
   input  logic       alm_en,
   input  logic       alm_ack,
   input  logic       mode12,
   output logic       sec_tick,
   output logic [3:0] s_lo,
   output logic [3:0] s_hi,
   output logic [3:0] m_lo,
   output logic [3:0] m_hi,
   output logic [3:0] h_lo,
   output logic [3:0] h_hi,
   output logic       pm,
   output logic       alarm
);

   localparam int             PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  PRESC_LAST  = PW'(CLK_HZ - 1);
   localparam logic [7:0]     ALM_HR_RST  = {4'(ALARM_RST_HR / 10), 4'(ALARM_RST_HR % 10)};
   localparam logic [7:0]     ALM_MIN_RST = {4'(ALARM_RST_MIN / 10), 4'(ALARM_RST_MIN % 10)};

   // Two-digit BCD increment that wraps to 00 after 'last' (59 for min/sec, 23 for hours).
   // Because only legal BCD values are ever stored, the units digit never passes 9.
   function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] last);
      logic [7:0] r;
      if (v == last) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // Maps a 24h BCD hour to {pm, 12h BCD hour}. BCD ordering matches numeric
   // ordering, so plain comparisons on the packed byte are safe.
   function automatic logic [8:0] to_12h(input logic [7:0] h);
      logic [8:0] r;
      if (h == 8'h00) begin
         r = {1'b0, 8'h12};
      end else if (h < 8'h12) begin
         r = {1'b0, h};
      end else if (h == 8'h12) begin
         r = {1'b1, 8'h12};
      end else if (h[7:4] == 4'd1) begin
         r = {1'b1, 4'd0, h[3:0] - 4'd2};
      end else if (h[3:0] < 4'd2) begin
         r = {1'b1, 4'd0, h[3:0] + 4'd8};
      end else begin
         r = {1'b1, 4'd1, h[3:0] - 4'd2};
      end
      return r;
   endfunction

   logic [PW-1:0] presc;
   logic          tick;
   logic [7:0]    second;
   logic [7:0]    minute;
   logic [7:0]    hour;
   logic [7:0]    alm_hour;
   logic [7:0]    alm_min;

   logic [7:0]    second_nx;
   logic [7:0]    minute_nx;
   logic [7:0]    hour_nx;
   logic [7:0]    alm_hour_nx;
   logic [7:0]    alm_min_nx;

   logic          alarm_hit;
   logic [7:0]    disp_h24;
   logic [7:0]    disp_min;
   logic [7:0]    disp_sec;
   logic [8:0]    disp_h12;
   logic [7:0]    disp_hour;
   logic          disp_pm;

   // A second elapses on the cycle the running prescaler sits at its last count.
   always_comb begin
      tick = run && (presc == PRESC_LAST);
   end

   // Prescaler advances only while running and keeps its count when stopped.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
      end else if (run) begin
         if (presc == PRESC_LAST) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Next time/alarm: full tick with carries first, then user increments on top of that result.
   always_comb begin
      second_nx   = second;
      minute_nx   = minute;
      hour_nx     = hour;
      alm_hour_nx = alm_hour;
      alm_min_nx  = alm_min;
      if (tick) begin
         second_nx = inc_bcd(second, 8'h59);
         if (second == 8'h59) begin
            minute_nx = inc_bcd(minute, 8'h59);
            if (minute == 8'h59) begin
               hour_nx = inc_bcd(hour, 8'h23);
            end
         end
      end
      if (alm_set) begin
         if (hr_inc) begin
            alm_hour_nx = inc_bcd(alm_hour, 8'h23);
         end
         if (min_inc) begin
            alm_min_nx = inc_bcd(alm_min, 8'h59);
         end
      end else begin
         if (hr_inc) begin
            hour_nx = inc_bcd(hour_nx, 8'h23);
         end
         if (min_inc) begin
            minute_nx = inc_bcd(minute_nx, 8'h59);
         end
      end
   end

   // Time and alarm registers, plus the registered second pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         second   <= 8'h00;
         minute   <= 8'h00;
         hour     <= 8'h00;
         alm_hour <= ALM_HR_RST;
         alm_min  <= ALM_MIN_RST;
         sec_tick <= 1'b0;
      end else begin
         second   <= second_nx;
         minute   <= minute_nx;
         hour     <= hour_nx;
         alm_hour <= alm_hour_nx;
         alm_min  <= alm_min_nx;
         sec_tick <= tick;
      end
   end

   // sec_tick marks that the stored time was just produced by a tick, so a manual
   // edit that lands on the alarm time can never qualify as a match.
   always_comb begin
      alarm_hit = sec_tick && (second == 8'h00) && (hour == alm_hour) && (minute == alm_min);
   end

   // Alarm latch: a new match beats a same-cycle acknowledge; disarming clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         alarm <= 1'b0;
      end else if (alarm_hit && alm_en) begin
         alarm <= 1'b1;
      end else if (!alm_en || alm_ack) begin
         alarm <= 1'b0;
      end
   end

   // Display source selection and optional 12h conversion of whichever hour is shown.
   always_comb begin
      disp_h24  = alm_set ? alm_hour : hour;
      disp_min  = alm_set ? alm_min : minute;
      disp_sec  = alm_set ? 8'h00 : second;
      disp_h12  = to_12h(disp_h24);
      disp_hour = mode12 ? disp_h12[7:0] : disp_h24;
      disp_pm   = mode12 ? disp_h12[8] : 1'b0;
   end

   // Output digit registers; they follow internal state and mode inputs by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_lo <= 4'd0;
         s_hi <= 4'd0;
         m_lo <= 4'd0;
         m_hi <= 4'd0;
         h_lo <= 4'd0;
         h_hi <= 4'd0;
         pm   <= 1'b0;
      end else begin
         s_lo <= disp_sec[3:0];
         s_hi <= disp_sec[7:4];
         m_lo <= disp_min[3:0];
         m_hi <= disp_min[7:4];
         h_lo <= disp_hour[3:0];
         h_hi <= disp_hour[7:4];
         pm   <= disp_pm;
      end
   end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed testbench for rtc_timekeeper with a small CLK_HZ; expected displays are
// queued as each step is driven and popped when the registered outputs are sampled.

module tb_rtc_timekeeper;

   localparam int CLK_HZ = 4;

   logic       clk;
   logic       reset;
   logic       run;
   logic       hr_inc;
   logic       min_inc;
   logic       alm_set;
   logic       alm_en;
   logic       alm_ack;
   logic       mode12;
   logic       sec_tick;
   logic [3:0] s_lo;
   logic [3:0] s_hi;
   logic [3:0] m_lo;
   logic [3:0] m_hi;
   logic [3:0] h_lo;
   logic [3:0] h_hi;
   logic       pm;
   logic       alarm;

   typedef struct {
      string       tag;
      logic [23:0] digits;
      logic        pm;
      logic        alarm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   rtc_timekeeper #(
      .CLK_HZ(CLK_HZ),
      .ALARM_RST_HR(7),
      .ALARM_RST_MIN(0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .hr_inc(hr_inc),
      .min_inc(min_inc),
      .alm_set(alm_set),
      .alm_en(alm_en),
      .alm_ack(alm_ack),
      .mode12(mode12),
      .sec_tick(sec_tick),
      .s_lo(s_lo),
      .s_hi(s_hi),
      .m_lo(m_lo),
      .m_hi(m_hi),
      .h_lo(h_lo),
      .h_hi(h_hi),
      .pm(pm),
      .alarm(alarm)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n rising edges, then settle 1 unit so outputs are stable and inputs can change.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("[TB] check %s mismatched", tag);
      end
   endtask

   task automatic expectDisp(input string tag, input logic [23:0] d, input logic p, input logic a);
      exp_t e;
      e.tag    = tag;
      e.digits = d;
      e.pm     = p;
      e.alarm  = a;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checkVal("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         checkVal({e.tag, "_digits"}, {8'd0, h_hi, h_lo, m_hi, m_lo, s_hi, s_lo}, {8'd0, e.digits});
         checkVal({e.tag, "_pm"}, {31'd0, pm}, {31'd0, e.pm});
         checkVal({e.tag, "_alarm"}, {31'd0, alarm}, {31'd0, e.alarm});
      end
   endtask

   // Pulse hr_inc and/or min_inc together for n separate cycles.
   task automatic applyStimulus(input logic hr, input logic mn, input int n);
      repeat (n) begin
         hr_inc  = hr;
         min_inc = mn;
         step(1);
         hr_inc  = 1'b0;
         min_inc = 1'b0;
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   // Wait for n second pulses within a bounded cycle budget; returns right after the last one.
   task automatic waitTicks(input string tag, input int n);
      int seen;
      int budget;
      seen   = 0;
      budget = n * CLK_HZ + 16;
      while (seen < n && budget > 0) begin
         step(1);
         budget--;
         if (sec_tick === 1'b1) seen++;
      end
      checkVal(tag, seen, n);
   endtask

   initial begin
      int cnt;
      reset   = 1'b1;
      run     = 1'b0;
      hr_inc  = 1'b0;
      min_inc = 1'b0;
      alm_set = 1'b0;
      alm_en  = 1'b0;
      alm_ack = 1'b0;
      mode12  = 1'b0;

      // 1. Reset state, tick cadence, run/hold behaviour
      step(2);
      reset = 1'b0;
      expectDisp("reset", 24'h000000, 1'b0, 1'b0);
      checkOutput();
      checkVal("reset_tick", {31'd0, sec_tick}, 32'd0);
      run = 1'b1;
      step(3);
      checkVal("tick_before_first", {31'd0, sec_tick}, 32'd0);
      step(1);
      checkVal("tick_first", {31'd0, sec_tick}, 32'd1);
      step(3);
      checkVal("tick_gap", {31'd0, sec_tick}, 32'd0);
      step(1);
      checkVal("tick_second", {31'd0, sec_tick}, 32'd1);
      waitTicks("ticks_to_60", 58);
      expectDisp("one_minute", 24'h000100, 1'b0, 1'b0);
      step(1);
      checkOutput();
      run = 1'b0;
      cnt = 0;
      repeat (10) begin
         step(1);
         if (sec_tick === 1'b1) cnt++;
      end
      checkVal("hold_no_tick", cnt, 0);
      run = 1'b1;
      step(2);
      checkVal("resume_early", {31'd0, sec_tick}, 32'd0);
      step(1);
      checkVal("resume_keeps_count", {31'd0, sec_tick}, 32'd1);
      run = 1'b0;

      // 2. Full-day rollover
      doReset();
      applyStimulus(1'b1, 1'b0, 23);
      applyStimulus(1'b0, 1'b1, 59);
      run = 1'b1;
      waitTicks("ticks_to_235959", 59);
      run = 1'b0;
      expectDisp("t235959", 24'h235959, 1'b0, 1'b0);
      step(2);
      checkOutput();
      run = 1'b1;
      waitTicks("tick_midnight", 1);
      run = 1'b0;
      expectDisp("midnight", 24'h000000, 1'b0, 1'b0);
      step(2);
      checkOutput();

      // 3. Setting wraps without carries
      doReset();
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b0, 1'b1, 59);
      run = 1'b1;
      waitTicks("ticks_to_30s", 30);
      run = 1'b0;
      expectDisp("t105930", 24'h105930, 1'b0, 1'b0);
      step(2);
      checkOutput();
      applyStimulus(1'b0, 1'b1, 1);
      expectDisp("min_wrap_nocarry", 24'h100030, 1'b0, 1'b0);
      step(2);
      checkOutput();
      applyStimulus(1'b1, 1'b0, 13);
      expectDisp("hour23", 24'h230030, 1'b0, 1'b0);
      step(2);
      checkOutput();
      applyStimulus(1'b1, 1'b0, 1);
      expectDisp("hour_wrap", 24'h000030, 1'b0, 1'b0);
      step(2);
      checkOutput();

      // 4. 12h display conversion
      applyStimulus(1'b0, 1'b1, 15);
      mode12 = 1'b1;
      expectDisp("m12_midnight", 24'h121530, 1'b0, 1'b0);
      step(2);
      checkOutput();
      applyStimulus(1'b1, 1'b0, 12);
      applyStimulus(1'b0, 1'b1, 45);
      expectDisp("m12_noon", 24'h120030, 1'b1, 1'b0);
      step(2);
      checkOutput();
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 5);
      expectDisp("m12_1pm", 24'h010530, 1'b1, 1'b0);
      step(2);
      checkOutput();
      mode12 = 1'b0;
      expectDisp("m24_13h", 24'h130530, 1'b0, 1'b0);
      step(2);
      checkOutput();

      // 5. Alarm setting, trigger, acknowledge, disarmed
      alm_set = 1'b1;
      expectDisp("alarm_reset_val", 24'h070000, 1'b0, 1'b0);
      step(2);
      checkOutput();
      applyStimulus(1'b0, 1'b1, 2);
      applyStimulus(1'b1, 1'b0, 17);
      expectDisp("alarm_0002", 24'h000200, 1'b0, 1'b0);
      step(2);
      checkOutput();
      alm_set = 1'b0;
      expectDisp("time_kept", 24'h130530, 1'b0, 1'b0);
      step(2);
      checkOutput();
      applyStimulus(1'b1, 1'b0, 11);
      applyStimulus(1'b0, 1'b1, 56);
      alm_en = 1'b1;
      run    = 1'b1;
      waitTicks("ticks_to_alarm", 30);
      run = 1'b0;
      expectDisp("alarm_fire", 24'h000200, 1'b0, 1'b1);
      step(1);
      checkOutput();
      alm_ack = 1'b1;
      step(1);
      alm_ack = 1'b0;
      checkVal("alarm_ack", {31'd0, alarm}, 32'd0);
      alm_en = 1'b0;
      applyStimulus(1'b0, 1'b1, 59);
      run = 1'b1;
      waitTicks("ticks_disarmed", 60);
      run = 1'b0;
      expectDisp("alarm_disarmed", 24'h000200, 1'b0, 1'b0);
      step(2);
      checkOutput();

      // 6. Tick and increment together, both increments together, reset mid-count
      applyStimulus(1'b1, 1'b0, 12);
      applyStimulus(1'b0, 1'b1, 32);
      run = 1'b1;
      waitTicks("ticks_to_123459", 59);
      run = 1'b0;
      expectDisp("t123459", 24'h123459, 1'b0, 1'b0);
      step(2);
      checkOutput();
      run = 1'b1;
      step(3);
      min_inc = 1'b1;
      step(1);
      min_inc = 1'b0;
      run     = 1'b0;
      checkVal("tick_with_inc", {31'd0, sec_tick}, 32'd1);
      expectDisp("tick_then_inc", 24'h123600, 1'b0, 1'b0);
      step(2);
      checkOutput();
      applyStimulus(1'b1, 1'b1, 1);
      expectDisp("both_inc", 24'h133700, 1'b0, 1'b0);
      step(2);
      checkOutput();
      run    = 1'b1;
      alm_en = 1'b1;
      step(2);
      reset  = 1'b1;
      hr_inc = 1'b1;
      step(1);
      reset  = 1'b0;
      hr_inc = 1'b0;
      run    = 1'b0;
      expectDisp("mid_reset", 24'h000000, 1'b0, 1'b0);
      checkOutput();
      checkVal("mid_reset_tick", {31'd0, sec_tick}, 32'd0);
      expectDisp("after_reset", 24'h000000, 1'b0, 1'b0);
      step(2);
      checkOutput();
      alm_set = 1'b1;
      expectDisp("alarm_reloaded", 24'h070000, 1'b0, 1'b0);
      step(2);
      checkOutput();
      alm_set = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
